// File: rtl/imem_fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Used by all builds; ERR is only reachable when IFETCH_ALIGN_CHECK_EN is defined.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam int          BYTE_CNT_W     = 2;
  localparam logic [31:0] PC_STEP        = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_seq_if.sv
// Memory port, redirect and instruction handshake bundle for imem_fetch_seq.
// misalign_err exists only when IFETCH_ALIGN_CHECK_EN is defined.
interface imem_fetch_seq_if #(
  parameter int ADR_W = 16
);
  logic [ADR_W-1:0] mem_adr;
  logic             mem_rd;
  logic [7:0]       mem_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst_out;
  logic [31:0]      inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic             misalign_err;

  modport master (
    output mem_adr, mem_rd, inst_valid, inst_out, inst_pc, misalign_err,
    input  mem_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  mem_adr, mem_rd, inst_valid, inst_out, inst_pc, misalign_err,
    output mem_data, redirect_valid, redirect_pc, inst_ready
  );
`else
  modport master (
    output mem_adr, mem_rd, inst_valid, inst_out, inst_pc,
    input  mem_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  mem_adr, mem_rd, inst_valid, inst_out, inst_pc,
    output mem_data, redirect_valid, redirect_pc, inst_ready
  );
`endif
endinterface

// File: rtl/imem_fetch_seq_assembler.sv
// 4x8 lane register that gathers instruction bytes into a little-endian word.
// Independent of IFETCH_ALIGN_CHECK_EN.
module imem_byte_assembler
  import imem_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [BYTE_CNT_W-1:0] sel,
  input  logic [7:0]            din,
  output logic [31:0]           word
);

  logic [7:0] lane [BYTES_PER_WORD];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) lane[i] <= 8'h00;
    end else if (we) begin
      lane[sel] <= din;
    end
  end

  // Write-through view: the lane being written shows din, so the last byte
  // can be captured into the full word on the same edge it arrives.
  always_comb begin
    word = {lane[3], lane[2], lane[1], lane[0]};
    if (we && !clr) word[8*sel +: 8] = din;
  end

endmodule

// File: rtl/imem_fetch_seq.sv
// Byte-serial instruction fetch sequencer: 4 reads per word, valid/ready to core.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned PCs in an ERR state.
module imem_fetch_seq
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADR_W    = 16
) (
  input logic             clk,
  input logic             rst,
  imem_fetch_seq_if.master bus
);

  localparam logic [BYTE_CNT_W-1:0] LAST_LANE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  fetch_state_t          state;
  logic [31:0]           pc;
  logic [BYTE_CNT_W-1:0] cnt;
  logic [ADR_W-1:0]      mem_adr;
  logic                  mem_rd;
  logic                  inst_valid;
  logic [31:0]           inst_out;
  logic [31:0]           inst_pc;
  logic [31:0]           asm_word;
  logic [31:0]           pc_step;
  logic [ADR_W-1:0]      adr_next;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic                  misalign_err;
`endif

  assign pc_step  = pc + PC_STEP;
  assign adr_next = pc[ADR_W-1:0] + {{(ADR_W-BYTE_CNT_W){1'b0}}, cnt} + 1'b1;

  imem_byte_assembler u_asm (
    .clk  (clk),
    .clr  (rst | bus.redirect_valid),
    .we   (state == FETCH),
    .sel  (cnt),
    .din  (bus.mem_data),
    .word (asm_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      cnt        <= '0;
      mem_adr    <= '0;
      mem_rd     <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // A coincident handshake is simply treated as consumed.
      pc         <= bus.redirect_pc;
      cnt        <= '0;
      inst_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (is_misaligned(bus.redirect_pc)) begin
        state        <= ERR;
        mem_rd       <= 1'b0;
        misalign_err <= 1'b1;
      end else begin
        state        <= FETCH;
        mem_rd       <= 1'b1;
        mem_adr      <= bus.redirect_pc[ADR_W-1:0];
        misalign_err <= 1'b0;
      end
`else
      state   <= FETCH;
      mem_rd  <= 1'b1;
      mem_adr <= bus.redirect_pc[ADR_W-1:0];
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (is_misaligned(pc)) begin
            state        <= ERR;
            misalign_err <= 1'b1;
          end else begin
            state   <= FETCH;
            mem_rd  <= 1'b1;
            mem_adr <= pc[ADR_W-1:0];
          end
`else
          state   <= FETCH;
          mem_rd  <= 1'b1;
          mem_adr <= pc[ADR_W-1:0];
`endif
        end
        FETCH: begin
          if (cnt == LAST_LANE) begin
            state      <= HOLD;
            cnt        <= '0;
            mem_rd     <= 1'b0;
            inst_valid <= 1'b1;
            inst_out   <= asm_word;
            inst_pc    <= pc;
          end else begin
            cnt     <= cnt + 1'b1;
            mem_adr <= adr_next;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            state      <= FETCH;
            pc         <= pc_step;
            cnt        <= '0;
            inst_valid <= 1'b0;
            mem_rd     <= 1'b1;
            mem_adr    <= pc_step[ADR_W-1:0];
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_adr    = mem_adr;
  assign bus.mem_rd     = mem_rd;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_out   = inst_out;
  assign bus.inst_pc    = inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bus.misalign_err = misalign_err;
`endif

endmodule

// File: tb/tb_imem_fetch_seq.sv
// Directed bench for imem_fetch_seq: fetch, stall, redirects, reset, address wrap.
// Misalignment checks switch with IFETCH_ALIGN_CHECK_EN.
module tb_imem_fetch_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [7:0] mem [0:65535];

  imem_fetch_seq_if #(.ADR_W(16)) bus ();
  imem_fetch_seq_if #(.ADR_W(16)) bus2 ();

  imem_fetch_seq #(.RESET_PC(32'h0000_0000), .ADR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  imem_fetch_seq #(.RESET_PC(32'h0000_FFFC), .ADR_W(16)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  assign bus.mem_data  = mem[bus.mem_adr];
  assign bus2.mem_data = mem[bus2.mem_adr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", bus.mem_rd); end
    total++; if (bus.mem_adr !== 16'h0000) begin bad++; $display("FAIL reset_adr got=%h exp=0000", bus.mem_adr); end
    total++; if (bus.inst_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.inst_out); end
    total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.inst_pc); end
    total++; if (bus2.mem_adr !== 16'h0000) begin bad++; $display("FAIL reset_adr2 got=%h exp=0000", bus2.mem_adr); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL idle_rd got=%b exp=0", bus.mem_rd); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus.mem_rd !== 1'b1 || bus.mem_adr !== 16'(k) || bus.inst_valid !== 1'b0) begin
        bad++; $display("FAIL first_adr k=%0d got rd=%b adr=%h v=%b exp rd=1 adr=%h v=0", k, bus.mem_rd, bus.mem_adr, bus.inst_valid, 16'(k));
      end
    end
    step();
    total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", bus.inst_valid); end
    total++; if (bus.inst_out !== 32'h1234_5678) begin bad++; $display("FAIL first_out got=%h exp=12345678", bus.inst_out); end
    total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL first_pc got=%h exp=0", bus.inst_pc); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL hold_rd got=%b exp=0", bus.mem_rd); end
    step();
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_adr !== 16'h0004) begin
      bad++; $display("FAIL next_fetch got v=%b rd=%b adr=%h exp v=0 rd=1 adr=0004", bus.inst_valid, bus.mem_rd, bus.mem_adr);
    end
  endtask

  task automatic test_stall();
    bus.inst_ready = 1'b0;
    step(); step(); step();
    total++; if (bus.mem_adr !== 16'h0007) begin bad++; $display("FAIL stall_pre_adr got=%h exp=0007", bus.mem_adr); end
    step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h0706_0504 || bus.inst_pc !== 32'h4 ||
          bus.mem_rd !== 1'b0 || bus.mem_adr !== 16'h0007) begin
        bad++; $display("FAIL stall_hold i=%0d got v=%b out=%h pc=%h rd=%b adr=%h exp v=1 out=07060504 pc=4 rd=0 adr=0007",
                        i, bus.inst_valid, bus.inst_out, bus.inst_pc, bus.mem_rd, bus.mem_adr);
      end
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_adr !== 16'h0008) begin
      bad++; $display("FAIL stall_release got v=%b rd=%b adr=%h exp v=0 rd=1 adr=0008", bus.inst_valid, bus.mem_rd, bus.mem_adr);
    end
  endtask

  task automatic test_redirect_mid_fetch();
    step(); step();
    total++; if (bus.mem_adr !== 16'h000A) begin bad++; $display("FAIL redir_cnt2_adr got=%h exp=000a", bus.mem_adr); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    step();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.mem_adr !== 16'h0040 || bus.mem_rd !== 1'b1 || bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL redir_adr got adr=%h rd=%b v=%b exp adr=0040 rd=1 v=0", bus.mem_adr, bus.mem_rd, bus.inst_valid);
    end
    for (int k = 1; k < 4; k++) begin
      step();
      total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL redir_partial k=%0d got v=%b exp=0", k, bus.inst_valid); end
    end
    step();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_out !== 32'h4342_4140) begin
      bad++; $display("FAIL redir_word got v=%b pc=%h out=%h exp v=1 pc=00000040 out=43424140", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
  endtask

  task automatic test_redirect_on_handshake();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0010;
    bus.inst_ready     = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    total++; if (bus.mem_adr !== 16'h0010) begin bad++; $display("FAIL hs_setup_adr got=%h exp=0010", bus.mem_adr); end
    step(); step(); step(); step();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10 || bus.inst_out !== 32'h1312_1110) begin
      bad++; $display("FAIL hs_setup_word got v=%b pc=%h out=%h exp v=1 pc=00000010 out=13121110", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0080;
    step();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_adr !== 16'h0080) begin
      bad++; $display("FAIL hs_redir got v=%b adr=%h exp v=0 adr=0080", bus.inst_valid, bus.mem_adr);
    end
    step(); step(); step(); step();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h80 || bus.inst_out !== 32'h8382_8180) begin
      bad++; $display("FAIL hs_word got v=%b pc=%h out=%h exp v=1 pc=00000080 out=83828180", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
  endtask

  task automatic test_reset_mid_hold();
    rst = 1'b1;
    step();
    total++;
    if (bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h0 || bus.inst_out !== 32'h0 || bus.mem_rd !== 1'b0 || bus.mem_adr !== 16'h0) begin
      bad++; $display("FAIL rst_hold got v=%b pc=%h out=%h rd=%b adr=%h exp all zero",
                      bus.inst_valid, bus.inst_pc, bus.inst_out, bus.mem_rd, bus.mem_adr);
    end
    rst = 1'b0;
    step();
    total++; if (bus.mem_adr !== 16'h0 || bus.mem_rd !== 1'b1) begin bad++; $display("FAIL rst_restart got adr=%h rd=%b exp adr=0000 rd=1", bus.mem_adr, bus.mem_rd); end
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0022;
    step();
    bus.redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    total++;
    if (bus.misalign_err !== 1'b1 || bus.mem_rd !== 1'b0 || bus.inst_valid !== 1'b0) begin
      bad++; $display("FAIL mis_err got err=%b rd=%b v=%b exp err=1 rd=0 v=0", bus.misalign_err, bus.mem_rd, bus.inst_valid);
    end
    step(); step();
    total++;
    if (bus.misalign_err !== 1'b1 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL mis_stay got err=%b rd=%b exp err=1 rd=0", bus.misalign_err, bus.mem_rd);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0024;
    step();
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.misalign_err !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_adr !== 16'h0024) begin
      bad++; $display("FAIL mis_clear got err=%b rd=%b adr=%h exp err=0 rd=1 adr=0024", bus.misalign_err, bus.mem_rd, bus.mem_adr);
    end
    step(); step(); step(); step();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h24 || bus.inst_out !== 32'h2726_2524) begin
      bad++; $display("FAIL mis_resume got v=%b pc=%h out=%h exp v=1 pc=00000024 out=27262524", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
`else
    total++; if (bus.mem_adr !== 16'h0022 || bus.mem_rd !== 1'b1) begin bad++; $display("FAIL unal_adr got adr=%h rd=%b exp adr=0022 rd=1", bus.mem_adr, bus.mem_rd); end
    step(); step(); step();
    total++; if (bus.mem_adr !== 16'h0025) begin bad++; $display("FAIL unal_last got=%h exp=0025", bus.mem_adr); end
    step();
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h22 || bus.inst_out !== 32'h2524_2322) begin
      bad++; $display("FAIL unal_word got v=%b pc=%h out=%h exp v=1 pc=00000022 out=25242322", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
`endif
  endtask

  task automatic test_addr_wrap();
    bus2.inst_ready = 1'b1;
    rst2 = 1'b0;
    total++; if (bus2.mem_rd !== 1'b0) begin bad++; $display("FAIL wrap_idle got rd=%b exp=0", bus2.mem_rd); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus2.mem_adr !== 16'hFFFC + 16'(k) || bus2.mem_rd !== 1'b1) begin
        bad++; $display("FAIL wrap_adr_a k=%0d got adr=%h rd=%b exp adr=%h rd=1", k, bus2.mem_adr, bus2.mem_rd, 16'hFFFC + 16'(k));
      end
    end
    step();
    total++;
    if (bus2.inst_valid !== 1'b1 || bus2.inst_pc !== 32'h0000_FFFC || bus2.inst_out !== 32'hFFFE_FDFC) begin
      bad++; $display("FAIL wrap_word_a got v=%b pc=%h out=%h exp v=1 pc=0000fffc out=fffefdfc", bus2.inst_valid, bus2.inst_pc, bus2.inst_out);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (bus2.mem_adr !== 16'(k) || bus2.mem_rd !== 1'b1) begin
        bad++; $display("FAIL wrap_adr_b k=%0d got adr=%h rd=%b exp adr=%h rd=1", k, bus2.mem_adr, bus2.mem_rd, 16'(k));
      end
    end
    step();
    total++;
    if (bus2.inst_valid !== 1'b1 || bus2.inst_pc !== 32'h0001_0000 || bus2.inst_out !== 32'h1234_5678) begin
      bad++; $display("FAIL wrap_word_b got v=%b pc=%h out=%h exp v=1 pc=00010000 out=12345678", bus2.inst_valid, bus2.inst_pc, bus2.inst_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.inst_ready     = 1'b0;

    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_mid_fetch();
    test_redirect_on_handshake();
    test_reset_mid_hold();
    test_misaligned();
    test_addr_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
